md5_digest_match: RTL
=====================

// Module: md5_digest_match
// PURPOSE
//  Final stage of the MD5 search pipeline; sits directly after the 64th hash_op stage.
//  Adds the MD5 IV to the a/b/c/d state and forms the 128-bit digest in canonical byte order.
//  Compares the digest against a host-supplied target.
//  Captures the first matching 512-bit message block, keeps hit/tested counters, and presents
//  a sticky match flag to the host/UART controller.
// PARAMETERS
//  CNT_W  32  width of match_count and tested_count; both saturate at all-ones
// PORTS
//  clk           in   1    clock
//  reset         in   1    synchronous, active-high; clock clk
//  en            in   1    pipeline advance; shared with the hash_op chain
//  a_in..d_in    in   32   final MD5 state words from the last hash_op (4 ports)
//  m_in          in   512  message block travelling alongside the state
//  valid_in      in   1    a_in..d_in/m_in carry a real candidate
//  target_hash   in   128  target digest, byte 0 in [127:120]; must be stable while candidates are in flight
//  clear         in   1    synchronous clear of match/counter state (pipeline not flushed)
//  hash_valid    out  1    hash_out holds a valid candidate digest
//  hash_out      out  128  digest of the candidate at the stage-2 output
//  match_found   out  1    sticky; the first hit since reset/clear has been captured
//  match_msg     out  512  message block of the first hit
//  match_hash    out  128  digest of the first hit
//  match_count   out  CNT_W  number of hits since reset/clear
//  tested_count  out  CNT_W  number of valid candidates since reset/clear
// BEHAVIOUR
//  - Reset: every register and output is 0. This covers all pipeline registers, hash_valid,
//    hash_out, match_found, match_msg, match_hash and both counters.
//  - en=0: every register holds, including capture registers and counters. clear still acts.
//  - S1, on en:
//      sa = a_in + MD5_A0, sb = b_in + MD5_B0, sc = c_in + MD5_C0, sd = d_in + MD5_D0
//      (each addition mod 2^32); m1 <= m_in; v1 <= valid_in.
//  - S2, on en:
//      dig2 <= {bswap(sa), bswap(sb), bswap(sc), bswap(sd)}, where bswap reverses the 4 bytes.
//      m2 <= m1; v2 <= v1.
//      hit2 <= v1 && (digest == target_hash). The compare is combinational on the S1 outputs.
//  - hash_valid = v2 and hash_out = dig2, driven straight from registers.
//      Latency: a candidate accepted on an en edge appears on hash_valid 2 en-edges later.
//  - Capture, on en && hit2 && !match_found:
//      match_found <= 1, match_msg <= m2, match_hash <= dig2.
//      match_found therefore rises 3 en-edges after acceptance.
//      Later hits never overwrite match_msg or match_hash.
//  - Counters, on en:
//      match_count increments on hit2; tested_count increments on v2.
//      Both saturate at 2^CNT_W-1 with no wrap.
//  - clear=1 (synchronous, independent of en):
//      match_found, match_msg, match_hash and both counters go to 0.
//      clear beats capture and increment in the same cycle; a hit/valid coincident with clear
//      is dropped.
//      Pipeline regs (S1/S2) are not cleared; in-flight candidates are counted once clear is
//      released.
//  - reset mid-operation: all in-flight candidates are discarded. No partial capture survives.
//  - valid_in=0 bubbles propagate; they never hit, even if the garbage digest equals
//    target_hash.
// STRUCTURE
//  - Shared package md5_pkg:
//      MD5_A0=32'h67452301, MD5_B0=32'hefcdab89, MD5_C0=32'h98badcfe, MD5_D0=32'h10325476.
//      Function bswap32. Typedef-free 128-bit digest width constant DIGEST_W=128.
//  - One sub-module, sat_counter (params W; ports clk, reset, clr, inc, q), instantiated twice
//    for the counters.
//  - Everything else is inline.
// TESTING
//  1. Known vector MD5(""):
//     a_in=7246fad3, b_in=14e45506, c_in=ff4ea3eb, d_in=6e10a476, valid_in=1,
//     target=d41d8cd98f00b204e9800998ecf8427e
//     -> hash_out = target after 2 en-edges; match_found=1 after 3; match_count=1, tested_count=1.
//  2. Two hits, msg X then msg Y, back-to-back
//     -> match_msg=X, match_count=2, match_found stays 1.
//  3. Matching state words with valid_in=0 -> no hit; tested_count=0, match_found=0.
//  4. en toggled 1/0 every cycle during test 1 -> identical results, delivered after 2/3 en-edges
//     (not clock edges).
//  5. clear asserted on the same cycle hit2=1
//     -> all outputs 0 next cycle; a second hit afterwards is captured fresh.
//  6. CNT_W=4, 20 valid non-matching candidates -> tested_count sticks at 15;
//     reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - MD5 initial vector constants and byte-swap helper shared by the search pipeline
package md5_pkg;

    localparam int DIGEST_W = 128;

    localparam logic [31:0] MD5_A0 = 32'h67452301;
    localparam logic [31:0] MD5_B0 = 32'hefcdab89;
    localparam logic [31:0] MD5_C0 = 32'h98badcfe;
    localparam logic [31:0] MD5_D0 = 32'h10325476;

    // MD5 state words are little-endian; the canonical digest lists byte 0 first.
    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk    clock
//   reset  synchronous, active-high; zeroes q
//   clr    synchronous clear; zeroes q, wins over inc
//   inc    increment request; ignored once q is all-ones
//   q      count value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/md5_digest_match.sv
// rtl/md5_digest_match.sv - final MD5 stage: IV add, digest formation, target compare, hit capture
// Ports:
//   clk, reset           clock; synchronous active-high reset of every register
//   en                   pipeline advance shared with the hash_op chain
//   a_in..d_in           final state words from the last hash_op stage
//   m_in, valid_in       message block and its valid flag travelling with the state
//   target_hash          digest being searched for, byte 0 in [127:120]
//   clear                synchronous clear of capture/counter state (pipeline untouched)
//   hash_valid, hash_out candidate digest at the stage-2 output
//   match_found          sticky flag: first hit since reset/clear captured
//   match_msg/match_hash message block and digest of that first hit
//   match_count          hits since reset/clear (saturating)
//   tested_count         valid candidates since reset/clear (saturating)
module md5_digest_match
    import md5_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [31:0]         a_in,
    input  logic [31:0]         b_in,
    input  logic [31:0]         c_in,
    input  logic [31:0]         d_in,
    input  logic [511:0]        m_in,
    input  logic                valid_in,
    input  logic [DIGEST_W-1:0] target_hash,
    input  logic                clear,
    output logic                hash_valid,
    output logic [DIGEST_W-1:0] hash_out,
    output logic                match_found,
    output logic [511:0]        match_msg,
    output logic [DIGEST_W-1:0] match_hash,
    output logic [CNT_W-1:0]    match_count,
    output logic [CNT_W-1:0]    tested_count
);

    // Stage 1: state words with the IV folded in
    logic [31:0]  sa, sb, sc, sd;
    logic [511:0] m1;
    logic         v1;

    // Stage 2: canonical digest and its compare result
    logic [DIGEST_W-1:0] dig2;
    logic [511:0]        m2;
    logic                v2;
    logic                hit2;

    logic [DIGEST_W-1:0] dig1;

    assign dig1 = {bswap32(sa), bswap32(sb), bswap32(sc), bswap32(sd)};

    always_ff @(posedge clk) begin
        if (reset) begin
            sa   <= '0;
            sb   <= '0;
            sc   <= '0;
            sd   <= '0;
            m1   <= '0;
            v1   <= 1'b0;
            dig2 <= '0;
            m2   <= '0;
            v2   <= 1'b0;
            hit2 <= 1'b0;
        end else if (en) begin
            sa   <= a_in + MD5_A0;
            sb   <= b_in + MD5_B0;
            sc   <= c_in + MD5_C0;
            sd   <= d_in + MD5_D0;
            m1   <= m_in;
            v1   <= valid_in;
            dig2 <= dig1;
            m2   <= m1;
            v2   <= v1;
            // Bubbles carry garbage state, so the compare is qualified by v1.
            hit2 <= v1 && (dig1 == target_hash);
        end
    end

    assign hash_valid = v2;
    assign hash_out   = dig2;

    // First-hit capture; clear wins over a coincident hit, which is then lost.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            match_found <= 1'b0;
            match_msg   <= '0;
            match_hash  <= '0;
        end else if (en && hit2 && !match_found) begin
            match_found <= 1'b1;
            match_msg   <= m2;
            match_hash  <= dig2;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (en && hit2),
        .q     (match_count)
    );

    sat_counter #(.W(CNT_W)) u_tested_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (en && v2),
        .q     (tested_count)
    );

endmodule
